// File: rtl/vend_pkg.sv
// Shared definitions for the parametrised vending controller: state encoding
// and the width helper used to size select and counter fields.
package vend_pkg;

   localparam logic [1:0] ENC_IDLE     = 2'd0;
   localparam logic [1:0] ENC_COLLECT  = 2'd1;
   localparam logic [1:0] ENC_DISPENSE = 2'd2;
   localparam logic [1:0] ENC_CHANGE   = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = ENC_IDLE,
      COLLECT  = ENC_COLLECT,
      DISPENSE = ENC_DISPENSE,
      CHANGE   = ENC_CHANGE
   } state_t;

   // Never returns zero so a single-entry field still gets one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vend_edge_det.sv
// Rising-edge detector for debounced button levels. Both history registers
// preset to 1 so a level held high through reset never reports an edge.
module vend_edge_det #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] rise
);

   logic [W-1:0] cur_d, cur_q;
   logic [W-1:0] prev_d, prev_q;

   always_comb begin
      cur_d  = din;
      prev_d = cur_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q  <= '1;
         prev_q <= '1;
      end else begin
         cur_q  <= cur_d;
         prev_q <= prev_d;
      end
   end

   assign rise = cur_q & ~prev_q;

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: coin collection with overflow rejection,
// purchase, cancel/refund, unit-by-unit change return, Moore or Mealy dispense.
module vend_fsm_param #(
   parameter int CREDIT_W    = 4,
   parameter int NUM_PROD    = 8,
   parameter int PRICE       = 3,
   parameter int COIN_W      = 2,
   parameter int DISP_CYCLES = 4,
   parameter int MEALY       = 0,
   parameter int PROD_W      = vend_pkg::width_of(NUM_PROD)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin,
   input  logic [COIN_W-1:0]   coin_val,
   input  logic                accept,
   input  logic                cancel,
   input  logic [PROD_W-1:0]   sel,
   output logic                dispense,
   output logic [PROD_W-1:0]   product,
   output logic [CREDIT_W-1:0] credit,
   output logic                change,
   output logic                coin_reject,
   output logic                busy
);
   import vend_pkg::*;

   localparam int MAX_CREDIT = (1 << CREDIT_W) - 1;
   localparam int SUM_W      = ((CREDIT_W > COIN_W) ? CREDIT_W : COIN_W) + 1;
   localparam int CNT_W      = width_of(DISP_CYCLES);

   function automatic logic [SUM_W-1:0] coin_sum(input logic [CREDIT_W-1:0] c,
                                                 input logic [COIN_W-1:0]   v);
      return SUM_W'(c) + SUM_W'(v);
   endfunction

   function automatic logic coin_fits(input logic [SUM_W-1:0] s);
      return s <= SUM_W'(MAX_CREDIT);
   endfunction

   function automatic logic sel_valid(input logic [PROD_W-1:0] s);
      return int'(s) < NUM_PROD;
   endfunction

   logic coin_rise, accept_rise, cancel_rise;

   vend_edge_det #(.W(1)) u_coin_edge   (.clk(clk), .rst(rst), .din(coin),   .rise(coin_rise));
   vend_edge_det #(.W(1)) u_accept_edge (.clk(clk), .rst(rst), .din(accept), .rise(accept_rise));
   vend_edge_det #(.W(1)) u_cancel_edge (.clk(clk), .rst(rst), .din(cancel), .rise(cancel_rise));

   // Coin value and select travel one register behind the pins, aligned with the edges.
   logic [COIN_W-1:0]   coin_val_d, coin_val_q;
   logic [PROD_W-1:0]   sel_d, sel_q;

   state_t              state_d, state_q;
   logic [CREDIT_W-1:0] credit_d, credit_q;
   logic [PROD_W-1:0]   product_d, product_q;
   logic [CNT_W-1:0]    cnt_d, cnt_q;
   logic                dispense_d, dispense_q;
   logic                change_d, change_q;
   logic                coin_reject_d, coin_reject_q;
   logic                busy_d, busy_q;

   logic [SUM_W-1:0]    sum;
   logic                coin_ev, accept_ok, take;

   always_comb begin
      coin_val_d    = coin_val;
      sel_d         = sel;
      state_d       = state_q;
      credit_d      = credit_q;
      product_d     = product_q;
      cnt_d         = cnt_q;
      coin_reject_d = 1'b0;
      take          = 1'b0;
      sum           = coin_sum(credit_q, coin_val_q);
      coin_ev       = coin_rise && (coin_val_q != '0);
      accept_ok     = accept_rise && (credit_q >= CREDIT_W'(PRICE)) && sel_valid(sel_q);

      case (state_q)
         IDLE: begin
            if (coin_ev) begin
               if (coin_fits(sum)) begin
                  credit_d = CREDIT_W'(sum);
                  state_d  = COLLECT;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
         end
         COLLECT: begin
            // Cancel beats accept beats coin; a coin losing arbitration is refused.
            if (cancel_rise) begin
               state_d       = CHANGE;
               coin_reject_d = coin_ev;
            end else if (accept_ok) begin
               take          = 1'b1;
               product_d     = sel_q;
               credit_d      = credit_q - CREDIT_W'(PRICE);
               cnt_d         = CNT_W'(DISP_CYCLES - 1);
               state_d       = DISPENSE;
               coin_reject_d = coin_ev;
            end else if (coin_ev) begin
               if (coin_fits(sum)) credit_d = CREDIT_W'(sum);
               else                coin_reject_d = 1'b1;
            end
         end
         DISPENSE: begin
            coin_reject_d = coin_ev;
            if (cnt_q == '0) state_d = (credit_q != '0) ? CHANGE : IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         CHANGE: begin
            coin_reject_d = coin_ev;
            if (credit_q != '0)            credit_d = credit_q - CREDIT_W'(1);
            if (credit_q <= CREDIT_W'(1)) state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      dispense_d = (state_d == DISPENSE);
      change_d   = (state_d == CHANGE);
      busy_d     = dispense_d | change_d;
   end

   always_ff @(posedge clk) begin
      coin_val_q <= coin_val_d;
      sel_q      <= sel_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         credit_q      <= '0;
         product_q     <= '0;
         cnt_q         <= '0;
         dispense_q    <= 1'b0;
         change_q      <= 1'b0;
         coin_reject_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         product_q     <= product_d;
         cnt_q         <= cnt_d;
         dispense_q    <= dispense_d;
         change_q      <= change_d;
         coin_reject_q <= coin_reject_d;
         busy_q        <= busy_d;
      end
   end

   assign dispense    = dispense_q | (take & (MEALY != 0));
   assign product     = product_q;
   assign credit      = credit_q;
   assign change      = change_q;
   assign coin_reject = coin_reject_q;
   assign busy        = busy_q;

endmodule
